// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: shares one memory access path between the instruction
// fetch port (IF, read-only) and the data port (D, load/store). It grants one
// request at a time, drives a latched read or write strobe until the memory
// signals cmp_o, then returns a one-cycle ack with read data to the owner.
// An access that gets no cmp_o within TIMEOUT cycles completes with err=1.
//
// Ports:
//   clk, nrst                      clock, synchronous active-low reset
//   if_req/if_addr                 IF read request (held until if_ack)
//   if_ack/if_rdata                IF completion pulse and read data
//   d_read_req/d_write_req         D load/store request (held until d_ack)
//   d_addr/d_wdata                 D address and store data
//   d_ack/d_rdata                  D completion pulse and load data
//   err                            completion was a timeout (valid with ack)
//   mem_read_en/mem_write_en       memory strobes, high during ACCESS
//   mem_addr/mem_wdata             latched address and store data
//   cmp_o/mem_rdata                memory completion and read data
//   busy                           arbiter is in ACCESS or RESP
module mem_request_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read_req,
  input  logic              d_write_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              cmp_o,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Internal state; owner/last_grant encode 1 = D port, 0 = IF port.
  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last_d, last_d_n;
  logic             owner_d, owner_d_n;
  logic             op_wr, op_wr_n;

  // Next values of the registered outputs.
  logic              if_ack_n, d_ack_n, err_n, busy_n;
  logic              rd_en_n, wr_en_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, if_rdata_n, d_rdata_n;

  // Grant decision helpers.
  logic d_req, grant_d;
  logic [DATA_W-1:0] cap_data;

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_d_n   = last_d;
    owner_d_n  = owner_d;
    op_wr_n    = op_wr;
    if_ack_n   = 1'b0;
    d_ack_n    = 1'b0;
    rd_en_n    = 1'b0;
    wr_en_n    = 1'b0;
    err_n      = err;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    if_rdata_n = if_rdata;
    d_rdata_n  = d_rdata;
    d_req      = d_read_req | d_write_req;
    grant_d    = 1'b0;
    cap_data   = '0;

    case (state)
      ST_IDLE: begin
        if (if_req || d_req) begin
          // Under contention the port that did not win last time goes next.
          grant_d   = d_req && (!if_req || !last_d);
          owner_d_n = grant_d;
          last_d_n  = grant_d;
          op_wr_n   = grant_d && d_write_req;
          addr_n    = grant_d ? d_addr : if_addr;
          wdata_n   = (grant_d && d_write_req) ? d_wdata : '0;
          cnt_n     = '0;
          rd_en_n   = !(grant_d && d_write_req);
          wr_en_n   = grant_d && d_write_req;
          state_n   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cmp_o || (cnt == CNT_LAST)) begin
          // cmp_o wins over a timeout falling on the same edge.
          cap_data = (cmp_o && !op_wr) ? mem_rdata : '0;
          err_n    = !cmp_o;
          if (owner_d) begin
            d_rdata_n = cap_data;
            d_ack_n   = 1'b1;
          end else begin
            if_rdata_n = cap_data;
            if_ack_n   = 1'b1;
          end
          state_n = ST_RESP;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          rd_en_n = !op_wr;
          wr_en_n = op_wr;
        end
      end

      ST_RESP: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      last_d       <= 1'b0;
      owner_d      <= 1'b0;
      op_wr        <= 1'b0;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      err          <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      last_d       <= last_d_n;
      owner_d      <= owner_d_n;
      op_wr        <= op_wr_n;
      if_ack       <= if_ack_n;
      d_ack        <= d_ack_n;
      if_rdata     <= if_rdata_n;
      d_rdata      <= d_rdata_n;
      err          <= err_n;
      mem_read_en  <= rd_en_n;
      mem_write_en <= wr_en_n;
      mem_addr     <= addr_n;
      mem_wdata    <= wdata_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed testbench for mem_request_arbiter (TIMEOUT=4).
module tb_mem_request_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              nrst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_read_req, d_write_req;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  logic              mem_read_en, mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cmp_o;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  mem_request_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .if_rdata    (if_rdata),
    .d_read_req  (d_read_req),
    .d_write_req (d_write_req),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .err         (err),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cmp_o       (cmp_o),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; if_req = 1'b0; if_addr = '0; d_read_req = 1'b0; d_write_req = 1'b0;
    d_addr = '0; d_wdata = '0; cmp_o = 1'b0; mem_rdata = '0;

    // Reset then idle.
    tick(); tick();
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_if_rdata", 32'(if_rdata), 32'd0);
    check("rst_d_rdata", 32'(d_rdata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_re", 32'(mem_read_en), 32'd0);
    check("rst_we", 32'(mem_write_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    nrst = 1'b1;
    tick(); tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_en", 32'({mem_read_en, mem_write_en}), 32'd0);

    // IF read, cmp_o in the first ACCESS cycle.
    if_req = 1'b1; if_addr = 16'h0040;
    tick();
    check("ifr_re", 32'(mem_read_en), 32'd1);
    check("ifr_we", 32'(mem_write_en), 32'd0);
    check("ifr_addr", 32'(mem_addr), 32'h0040);
    check("ifr_wdata", 32'(mem_wdata), 32'd0);
    check("ifr_busy", 32'(busy), 32'd1);
    cmp_o = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    check("ifr_ack", 32'(if_ack), 32'd1);
    check("ifr_rdata", 32'(if_rdata), 32'hBEEF);
    check("ifr_err", 32'(err), 32'd0);
    check("ifr_d_ack", 32'(d_ack), 32'd0);
    check("ifr_resp_en", 32'({mem_read_en, mem_write_en}), 32'd0);
    if_req = 1'b0; cmp_o = 1'b0;
    tick();
    check("ifr_ack_drop", 32'(if_ack), 32'd0);
    check("ifr_idle_busy", 32'(busy), 32'd0);

    // D write with a three-cycle wait; store data changes mid-access.
    d_write_req = 1'b1; d_addr = 16'h1234; d_wdata = 16'hA5A5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dw_we", 32'(mem_write_en), 32'd1);
      check("dw_re", 32'(mem_read_en), 32'd0);
      check("dw_addr", 32'(mem_addr), 32'h1234);
      check("dw_wdata", 32'(mem_wdata), 32'hA5A5);
      d_wdata = 16'h0F0F + 16'(i);
      if (i == 2) cmp_o = 1'b1;
    end
    tick();
    check("dw_ack", 32'(d_ack), 32'd1);
    check("dw_rdata", 32'(d_rdata), 32'd0);
    check("dw_err", 32'(err), 32'd0);
    check("dw_if_ack", 32'(if_ack), 32'd0);
    check("dw_resp_we", 32'(mem_write_en), 32'd0);
    d_write_req = 1'b0; cmp_o = 1'b0;
    tick();
    check("dw_idle_ack", 32'(d_ack), 32'd0);

    // Contention from reset: grants alternate D, IF, D, IF.
    nrst = 1'b0; if_req = 1'b1; d_read_req = 1'b1; if_addr = 16'h0100; d_addr = 16'h0200;
    tick();
    check("ct_rst_en", 32'({mem_read_en, mem_write_en}), 32'd0);
    nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      tick();
      check("ct_re", 32'(mem_read_en), 32'd1);
      check("ct_we", 32'(mem_write_en), 32'd0);
      check("ct_addr", 32'(mem_addr), exp_d ? 32'h0200 : 32'h0100);
      cmp_o = 1'b1; mem_rdata = 16'h1000 + 16'(k);
      tick();
      check("ct_d_ack", 32'(d_ack), 32'(exp_d));
      check("ct_if_ack", 32'(if_ack), 32'(!exp_d));
      check("ct_rdata", exp_d ? 32'(d_rdata) : 32'(if_rdata), 32'h1000 + 32'(k));
      cmp_o = 1'b0;
      if (k == 3) begin
        if_req = 1'b0; d_read_req = 1'b0;
      end
      tick();
      check("ct_idle_acks", 32'({if_ack, d_ack}), 32'd0);
      check("ct_idle_en", 32'({mem_read_en, mem_write_en}), 32'd0);
    end
    tick();
    check("ct_done_busy", 32'(busy), 32'd0);

    // Timeout: no cmp_o, four ACCESS cycles, then err completion.
    d_read_req = 1'b1; d_addr = 16'h0300;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_re", 32'(mem_read_en), 32'd1);
    end
    tick();
    check("to_ack", 32'(d_ack), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_rdata", 32'(d_rdata), 32'd0);
    check("to_re_off", 32'(mem_read_en), 32'd0);
    d_read_req = 1'b0;
    tick();
    check("to_idle_busy", 32'(busy), 32'd0);

    // cmp_o on the last allowed ACCESS cycle beats the timeout.
    d_read_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tl_re", 32'(mem_read_en), 32'd1);
    end
    cmp_o = 1'b1; mem_rdata = 16'h7777;
    tick();
    check("tl_ack", 32'(d_ack), 32'd1);
    check("tl_err", 32'(err), 32'd0);
    check("tl_rdata", 32'(d_rdata), 32'h7777);
    d_read_req = 1'b0; cmp_o = 1'b0;
    tick();

    // Read+write together is a write; reset lands mid-access.
    d_read_req = 1'b1; d_write_req = 1'b1; d_addr = 16'h0400; d_wdata = 16'h5A5A;
    tick();
    check("rw_we", 32'(mem_write_en), 32'd1);
    check("rw_re", 32'(mem_read_en), 32'd0);
    check("rw_wdata", 32'(mem_wdata), 32'h5A5A);
    nrst = 1'b0;
    tick();
    check("mr_en", 32'({mem_read_en, mem_write_en}), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_acks", 32'({if_ack, d_ack}), 32'd0);
    check("mr_addr", 32'(mem_addr), 32'd0);

    // After release, D wins the first contention, then IF is served.
    d_write_req = 1'b0; if_req = 1'b1; if_addr = 16'h0500; nrst = 1'b1;
    tick();
    check("mr_grant_d_re", 32'(mem_read_en), 32'd1);
    check("mr_grant_d_addr", 32'(mem_addr), 32'h0400);
    cmp_o = 1'b1; mem_rdata = 16'h2222;
    tick();
    check("mr_d_ack", 32'(d_ack), 32'd1);
    check("mr_d_rdata", 32'(d_rdata), 32'h2222);
    d_read_req = 1'b0; cmp_o = 1'b0;
    tick();
    tick();
    check("mr_grant_if_addr", 32'(mem_addr), 32'h0500);
    check("mr_grant_if_re", 32'(mem_read_en), 32'd1);
    cmp_o = 1'b1; mem_rdata = 16'h3333;
    tick();
    check("mr_if_ack", 32'(if_ack), 32'd1);
    check("mr_if_rdata", 32'(if_rdata), 32'h3333);
    check("mr_if_d_ack", 32'(d_ack), 32'd0);
    if_req = 1'b0; cmp_o = 1'b0;
    tick();
    check("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Sequences and shares the single memory access path between two requesters: the instruction-fetch port (IF) and the data load/store port (D).
- Grants one request at a time.
- Drives mem_read_en/mem_write_en with latched address and data, then waits for cmp_o from the memory side.
- Returns a one-cycle registered ack and read data to the granted requester.
- Times out hung accesses.

Parameters:
ADDR_W, 16, address width for both ports and the memory side
DATA_W, 16, data width
TIMEOUT, 255, max cycles in ACCESS without cmp_o before an error completion (legal range 2..65535)

Ports:
clk  input  1  system clock
nrst  input  1  synchronous active-low reset
if_req  input  1  IF read request; held until if_ack
if_addr  input  ADDR_W  IF address
if_ack  output  1  one-cycle IF completion
if_rdata  output  DATA_W  IF read data, valid with if_ack
d_read_req  input  1  D load request; held until d_ack
d_write_req  input  1  D store request; held until d_ack
d_addr  input  ADDR_W  D address
d_wdata  input  DATA_W  D store data
d_ack  output  1  one-cycle D completion
d_rdata  output  DATA_W  D load data, valid with d_ack (0 for stores)
err  output  1  high with ack when the completion was a timeout
mem_read_en  output  1  memory read strobe
mem_write_en  output  1  memory write strobe
mem_addr  output  ADDR_W  latched access address
mem_wdata  output  DATA_W  latched store data
cmp_o  input  1  memory-side completion
mem_rdata  input  DATA_W  memory read data, valid with cmp_o
busy  output  1  high in ACCESS or RESP

Behaviour:
- Reset: synchronous on clk when nrst=0, taking priority over all other activity, including mid-access.
  - State goes to IDLE; last_grant = IF; timeout counter = 0.
  - All outputs read 0 on the cycle after the reset edge: both acks, rdata, err, both enables, mem_addr, mem_wdata, busy.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only here.
  - Only one port requesting: that port is granted.
  - Both ports requesting: grant the port not in last_grant (alternating). After reset, D wins first contention.
  - D with both d_read_req and d_write_req high is treated as a write.
  - On grant:
    - Latch address, write data (D write only), owner and op.
    - Update last_grant.
    - Clear the counter.
    - Go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - Exactly one of mem_read_en/mem_write_en is high, with mem_addr and mem_wdata stable from the latch.
  - mem_wdata reads 0 for reads.
  - cmp_o=1 at an edge:
    - Capture mem_rdata for reads, or 0 for writes, into the owner's rdata.
    - err=0; go to RESP.
  - cmp_o=0: counter increments.
    - If counter reaches TIMEOUT-1 while cmp_o is still 0, go to RESP with err=1 and rdata=0.
    - cmp_o on that same edge wins: normal completion.
- RESP (exactly one cycle):
  - Owner's ack=1 and err is valid.
  - Enables are 0; the non-owner's ack is 0.
  - Next state is always IDLE.
  - rdata/err hold their values until the next RESP overwrites them (only with ack are they meaningful).
- Requester contract: drop the request in the cycle ack is seen. A request still high in the following IDLE is a new request.
- Latency: grant edge → ACCESS; the first cmp_o edge → RESP. Ack appears the cycle after cmp_o is sampled. Minimum 3 cycles per transaction (IDLE, ACCESS, RESP).
- cmp_o outside ACCESS is ignored.
- Requester inputs changing during ACCESS do not affect the bus (latched values are used).
- busy = (state != IDLE).

Test Plan:
- Reset then idle: nrst=0 for 2 cycles, no requests → all outputs 0, busy=0, enables never assert.
- IF read: if_req=1, if_addr=0x0040; memory returns cmp_o one cycle into ACCESS with mem_rdata=0xBEEF → mem_read_en=1 with mem_addr=0x0040 for 1 cycle; next cycle if_ack=1, if_rdata=0xBEEF, err=0, d_ack=0.
- D write with 3-cycle wait: d_write_req=1, d_addr=0x1234, d_wdata=0xA5A5; cmp_o after 3 cycles → mem_write_en high for 3 cycles with stable addr/data; d_ack=1, d_rdata=0, err=0; changing d_wdata mid-access does not alter mem_wdata.
- Contention: if_req and d_read_req held continuously from reset, each served with 1-cycle cmp_o → grants D, IF, D, IF in order; every ack is a single pulse; no overlap of enables.
- Timeout: TIMEOUT=4, d_read_req=1, cmp_o never asserted → enable high 4 cycles, then d_ack=1, err=1, d_rdata=0, return to IDLE. Repeat with cmp_o=1 on the 4th ACCESS cycle → err=0, data returned.
- Reset mid-access: nrst=0 during ACCESS with mem_write_en=1 → next cycle enables=0, busy=0, no ack; after release, a pending if_req wins over d_read_req only if D is not pending (D wins first contention).
